result_tx: RTL

- Transmit-side framer for the miner's serial link; the counterpart of the work receive path.
- Queues 32-bit nonce results from the work handler in a small FIFO.
- Serializes each result into a fixed byte frame on the tx_data / new_tx_data / tx_busy byte interface of the AVR interface block.
- Sits between work_handler (new_result, result_data) and avr_interface (tx side).

---
 rtl/result_tx_if.sv | 19 +
 rtl/result_tx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/result_tx_if.sv
// rtl/result_tx_if.sv - byte link between result_tx and the AVR UART transmitter
// The master drives bytes and their strobe; the slave reports when it cannot take one.
interface result_tx_if;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy;

  modport master (
    output tx_data,
    output new_tx_data,
    input  tx_busy
  );

  modport slave (
    input  tx_data,
    input  new_tx_data,
    output tx_busy
  );
endinterface

// File: rtl/result_tx.sv
// rtl/result_tx.sv - queues nonce results and frames them as header + 4 LSB-first bytes
// RESULT_TX_CHECKSUM_EN appends a sixth XOR checksum byte to every frame.
module result_tx #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [7:0]  HEADER_BYTE = 8'h52
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          new_result,
  input  logic [31:0]                   result_data,
  input  logic                          work_restart,
  result_tx_if.master                   tx,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    overflow_cnt,
  output logic                          idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef RESULT_TX_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_overflow;
  logic [1:0]    r_state;
  logic [31:0]   r_shift;
  logic [2:0]    r_idx;
  logic [7:0]    r_last;
`ifdef RESULT_TX_CHECKSUM_EN
  logic [7:0]    r_csum;
`endif

  logic          w_full;
  logic          w_fresh;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_send;
  logic [7:0]    w_byte;
  logic [31:0]   w_head;

  // Full is judged on the pre-edge count, so a same-cycle pop never makes room.
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_fresh = new_result && !work_restart;
  assign w_push  = w_fresh && !w_full;
  assign w_drop  = w_fresh && w_full;
  assign w_pop   = (r_state == S_LOAD) && (r_count != '0);
  assign w_send  = (r_state == S_SEND) && !tx.tx_busy;
  assign w_head  = r_mem[r_rd_ptr];

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      3'd0: w_byte = HEADER_BYTE;
      3'd1: w_byte = r_shift[7:0];
      3'd2: w_byte = r_shift[15:8];
      3'd3: w_byte = r_shift[23:16];
      3'd4: w_byte = r_shift[31:24];
`ifdef RESULT_TX_CHECKSUM_EN
      3'd5: w_byte = r_csum;
`endif
      default: w_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= result_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 8'h00;
    end else begin
      if (work_restart) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
      if (w_drop && (r_overflow != 8'hFF)) begin
        r_overflow <= r_overflow + 8'd1;
      end
    end
  end

  // A frame that has left IDLE always runs to its last byte; restart only empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shift <= 32'h0;
      r_idx   <= 3'd0;
      r_last  <= 8'h00;
`ifdef RESULT_TX_CHECKSUM_EN
      r_csum  <= 8'h00;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_pop) begin
            r_shift <= w_head;
            r_idx   <= 3'd0;
`ifdef RESULT_TX_CHECKSUM_EN
            r_csum  <= HEADER_BYTE ^ w_head[7:0] ^ w_head[15:8] ^
                       w_head[23:16] ^ w_head[31:24];
`endif
            r_state <= S_SEND;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SEND: begin
          if (w_send) begin
            r_last  <= w_byte;
            r_idx   <= r_idx + 3'd1;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_idx <= LAST_IDX) begin
            r_state <= S_SEND;
          end else if (r_count != '0) begin
            r_state <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The strobe is combinational on tx_busy so a byte goes out in the very SEND cycle busy drops.
  assign tx.new_tx_data = w_send;
  assign tx.tx_data     = w_send ? w_byte : r_last;
  assign fifo_count     = r_count;
  assign overflow_cnt   = r_overflow;
  assign idle           = (r_state == S_IDLE) && (r_count == '0);

endmodule
